// File: rtl/any1_pkg.sv
// any1_pkg
//   Shared constants and types for the 3-D point transformer:
//   register addresses, coefficient slot indices inside a matrix set,
//   CMD bit positions and the packed CMD register layout.
package any1_pkg;

  localparam logic [7:0] XF_CMD  = 8'h40;
  localparam logic [7:0] XF_STAT = 8'h41;

  // Coefficient slots within one matrix set (row-major, translation last).
  localparam int NCOEF = 12;
  localparam int C_AA  = 0;
  localparam int C_AB  = 1;
  localparam int C_AC  = 2;
  localparam int C_AT  = 3;
  localparam int C_BA  = 4;
  localparam int C_BB  = 5;
  localparam int C_BC  = 6;
  localparam int C_BT  = 7;
  localparam int C_CA  = 8;
  localparam int C_CB  = 9;
  localparam int C_CC  = 10;
  localparam int C_CT  = 11;

  // CMD register bit positions.
  localparam int CMD_EN     = 0;
  localparam int CMD_SAT    = 1;
  localparam int CMD_SET_LO = 2;
  localparam int CMD_SET_HI = 3;

  // Field order mirrors the CMD bit positions above (en is bit 0).
  typedef struct packed {
    logic [1:0] set;
    logic       sat;
    logic       en;
  } cmd_t;

  // Slot index of coefficient (row, col); col 3 is the translation.
  function automatic int coef_idx(input int row, input int col);
    return row * 4 + col;
  endfunction

endpackage

// File: rtl/any1_xform_row.sv
// any1_xform_row
//   One output component of the affine transform, three pipeline stages:
//     S1: three products, shifted translation, bypass coordinate, mode bits
//     S2: rounded (half-up) and arithmetically shifted sum
//     S3: output register with saturate or wrap applied
//   Every register loads only when adv_i is high.
// Ports:
//   clk_i, rst_ni     clock, async active-low reset
//   adv_i             pipeline advance
//   en_i, sat_i       transform enable / saturation mode, sampled into S1
//   ca_i..cc_i, ct_i  row coefficients and translation of the active set
//   x_i, y_i, z_i     input point
//   byp_i             this row's input coordinate, used when en=0
//   res_o             S3 result
//   sat_evt_o         the S2 value is being clamped into S3 (qualify with S2 valid)
module any1_xform_row #(
  parameter int WID  = 32,
  parameter int FRAC = 16
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           adv_i,
  input  logic           en_i,
  input  logic           sat_i,
  input  logic [WID-1:0] ca_i,
  input  logic [WID-1:0] cb_i,
  input  logic [WID-1:0] cc_i,
  input  logic [WID-1:0] ct_i,
  input  logic [WID-1:0] x_i,
  input  logic [WID-1:0] y_i,
  input  logic [WID-1:0] z_i,
  input  logic [WID-1:0] byp_i,
  output logic [WID-1:0] res_o,
  output logic           sat_evt_o
);

  localparam int PW = 2 * WID;
  localparam int SW = 2 * WID + 2;
  localparam logic signed [SW-1:0] RND = SW'(1) << (FRAC - 1);

  // Operands are sign-extended to the product width so the multiply is
  // full-precision without relying on context-width rules.
  logic signed [PW-1:0] ca_x, cb_x, cc_x, x_x, y_x, z_x;
  assign ca_x = PW'($signed(ca_i));
  assign cb_x = PW'($signed(cb_i));
  assign cc_x = PW'($signed(cc_i));
  assign x_x  = PW'($signed(x_i));
  assign y_x  = PW'($signed(y_i));
  assign z_x  = PW'($signed(z_i));

  // S1
  logic signed [PW-1:0] pa_q, pb_q, pc_q;
  logic signed [SW-1:0] t_q;
  logic [WID-1:0]       byp1_q;
  logic                 en1_q, sat1_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pa_q   <= '0;
      pb_q   <= '0;
      pc_q   <= '0;
      t_q    <= '0;
      byp1_q <= '0;
      en1_q  <= 1'b0;
      sat1_q <= 1'b0;
    end else if (adv_i) begin
      pa_q   <= ca_x * x_x;
      pb_q   <= cb_x * y_x;
      pc_q   <= cc_x * z_x;
      t_q    <= SW'($signed(ct_i)) <<< FRAC;
      byp1_q <= byp_i;
      en1_q  <= en_i;
      sat1_q <= sat_i;
    end
  end

  // S2
  logic signed [SW-1:0] sum;
  logic signed [SW-1:0] r2_q;
  logic [WID-1:0]       byp2_q;
  logic                 en2_q, sat2_q;

  always_comb begin
    sum = SW'(pa_q) + SW'(pb_q) + SW'(pc_q) + t_q + RND;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r2_q   <= '0;
      byp2_q <= '0;
      en2_q  <= 1'b0;
      sat2_q <= 1'b0;
    end else if (adv_i) begin
      r2_q   <= sum >>> FRAC;
      byp2_q <= byp1_q;
      en2_q  <= en1_q;
      sat2_q <= sat1_q;
    end
  end

  // S3: the value fits in WID bits only if all bits from WID-1 upward agree.
  logic           oor;
  logic [WID-1:0] clamp_val;
  logic [WID-1:0] res_nxt;

  always_comb begin
    oor       = ~((&r2_q[SW-1:WID-1]) | ~(|r2_q[SW-1:WID-1]));
    clamp_val = r2_q[SW-1] ? {1'b1, {(WID-1){1'b0}}} : {1'b0, {(WID-1){1'b1}}};
    res_nxt   = r2_q[WID-1:0];
    if (!en2_q)
      res_nxt = byp2_q;
    else if (sat2_q && oor)
      res_nxt = clamp_val;
  end

  assign sat_evt_o = en2_q & sat2_q & oor;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      res_o <= '0;
    else if (adv_i)
      res_o <= res_nxt;
  end

endmodule

// File: rtl/any1_point_xform_pipe.sv
// any1_point_xform_pipe
//   Pipelined 3x4 fixed-point affine transform of a 3-D point stream.
//   Owns the register file (NMAT coefficient sets, CMD, STAT), the global
//   stall and the saturation counter; the math lives in three row instances.
// Ports:
//   clk_i, rst_ni                clock, async active-low reset
//   wr_i, adr_i, dat_i           register write port
//   dat_o                        registered read data (1-cycle latency)
//   pt_valid_i, pt_ready_o       input point handshake
//   pt_x_i, pt_y_i, pt_z_i       input coordinates
//   pt_valid_o, pt_ready_i       output point handshake
//   pt_x_o, pt_y_o, pt_z_o       output coordinates
module any1_point_xform_pipe
  import any1_pkg::*;
#(
  parameter int WID  = 32,
  parameter int FRAC = 16,
  parameter int NMAT = 4
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           wr_i,
  input  logic [7:0]     adr_i,
  input  logic [WID-1:0] dat_i,
  output logic [WID-1:0] dat_o,
  input  logic           pt_valid_i,
  output logic           pt_ready_o,
  input  logic [WID-1:0] pt_x_i,
  input  logic [WID-1:0] pt_y_i,
  input  logic [WID-1:0] pt_z_i,
  output logic           pt_valid_o,
  input  logic           pt_ready_i,
  output logic [WID-1:0] pt_x_o,
  output logic [WID-1:0] pt_y_o,
  output logic [WID-1:0] pt_z_o
);

  localparam logic [WID-1:0] ONE = WID'(1) << FRAC;

  logic [WID-1:0] coef_q [NMAT][NCOEF];
  cmd_t           cmd_q;
  logic [15:0]    stat_q;

  // Pipeline valids and the single global stall.
  logic v1_q, v2_q, v3_q;
  logic adv;

  assign adv        = ~v3_q | pt_ready_i;
  assign pt_ready_o = adv;
  assign pt_valid_o = v3_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
    end else if (adv) begin
      v1_q <= pt_valid_i;
      v2_q <= v1_q;
      v3_q <= v2_q;
    end
  end

  // Coefficient address decode.
  logic       coef_hit;
  logic [1:0] coef_set;
  logic [3:0] coef_k;

  assign coef_set = adr_i[5:4];
  assign coef_k   = adr_i[3:0];
  assign coef_hit = (adr_i[7:6] == 2'b00) &&
                    ({1'b0, coef_set} < 3'(NMAT)) &&
                    (coef_k < 4'(NCOEF));

  logic [1:0] set_wr;
  assign set_wr = ({1'b0, dat_i[CMD_SET_HI:CMD_SET_LO]} >= 3'(NMAT)) ?
                  2'(NMAT - 1) : dat_i[CMD_SET_HI:CMD_SET_LO];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int s = 0; s < NMAT; s++)
        for (int k = 0; k < NCOEF; k++)
          coef_q[s][k] <= (k == C_AA || k == C_BB || k == C_CC) ? ONE : '0;
      cmd_q <= '0;
    end else if (wr_i) begin
      if (coef_hit)
        coef_q[coef_set][coef_k] <= dat_i;
      if (adr_i == XF_CMD) begin
        cmd_q.en  <= dat_i[CMD_EN];
        cmd_q.sat <= dat_i[CMD_SAT];
        cmd_q.set <= set_wr;
      end
    end
  end

  // Datapath rows; coefficients come straight from the active set so that
  // a same-cycle register write is seen only by later points.
  logic [WID-1:0] pt_in  [3];
  logic [WID-1:0] pt_res [3];
  logic [2:0]     sat_evt;

  assign pt_in[0] = pt_x_i;
  assign pt_in[1] = pt_y_i;
  assign pt_in[2] = pt_z_i;

  for (genvar r = 0; r < 3; r++) begin : g_row
    any1_xform_row #(
      .WID  (WID),
      .FRAC (FRAC)
    ) u_row (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .adv_i     (adv),
      .en_i      (cmd_q.en),
      .sat_i     (cmd_q.sat),
      .ca_i      (coef_q[cmd_q.set][coef_idx(r, 0)]),
      .cb_i      (coef_q[cmd_q.set][coef_idx(r, 1)]),
      .cc_i      (coef_q[cmd_q.set][coef_idx(r, 2)]),
      .ct_i      (coef_q[cmd_q.set][coef_idx(r, 3)]),
      .x_i       (pt_x_i),
      .y_i       (pt_y_i),
      .z_i       (pt_z_i),
      .byp_i     (pt_in[r]),
      .res_o     (pt_res[r]),
      .sat_evt_o (sat_evt[r])
    );
  end

  assign pt_x_o = pt_res[0];
  assign pt_y_o = pt_res[1];
  assign pt_z_o = pt_res[2];

  // Saturation counter: counts clamped components as they load into S3,
  // sticks at all-ones; a STAT write wins over a same-cycle event.
  logic [1:0]  evt_cnt;
  logic [16:0] stat_sum;
  logic [15:0] stat_nxt;

  assign evt_cnt  = {1'b0, sat_evt[0]} + {1'b0, sat_evt[1]} + {1'b0, sat_evt[2]};
  assign stat_sum = {1'b0, stat_q} + 17'(evt_cnt);
  assign stat_nxt = stat_sum[16] ? 16'hFFFF : stat_sum[15:0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      stat_q <= '0;
    else if (wr_i && adr_i == XF_STAT)
      stat_q <= '0;
    else if (adv && v2_q && (|sat_evt))
      stat_q <= stat_nxt;
  end

  // Read port.
  logic [WID-1:0] rd_data;

  always_comb begin
    rd_data = '0;
    if (coef_hit)
      rd_data = coef_q[coef_set][coef_k];
    else if (adr_i == XF_CMD)
      rd_data = WID'(cmd_q);
    else if (adr_i == XF_STAT)
      rd_data = WID'(stat_q);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      dat_o <= '0;
    else
      dat_o <= rd_data;
  end

endmodule

// File: tb/tb_any1_point_xform_pipe.sv
module tb_any1_point_xform_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_i;
  logic [7:0]  adr_i;
  logic [31:0] dat_i;
  logic [31:0] dat_o;
  logic        pt_valid_i, pt_ready_o, pt_valid_o, pt_ready_i;
  logic [31:0] pt_x_i, pt_y_i, pt_z_i, pt_x_o, pt_y_o, pt_z_o;

  any1_point_xform_pipe #(.WID(32), .FRAC(16), .NMAT(4)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .wr_i       (wr_i),
    .adr_i      (adr_i),
    .dat_i      (dat_i),
    .dat_o      (dat_o),
    .pt_valid_i (pt_valid_i),
    .pt_ready_o (pt_ready_o),
    .pt_x_i     (pt_x_i),
    .pt_y_i     (pt_y_i),
    .pt_z_i     (pt_z_i),
    .pt_valid_o (pt_valid_o),
    .pt_ready_i (pt_ready_i),
    .pt_x_o     (pt_x_o),
    .pt_y_o     (pt_y_o),
    .pt_z_o     (pt_z_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  cmd;
    logic [31:0] aa, at;
    logic [31:0] x, y, z;
    logic [31:0] ex, ey, ez;
    logic [15:0] est;
  } vec_t;

  vec_t vecs [7];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    wr_i  = 1'b1;
    adr_i = a;
    dat_i = d;
    @(negedge clk);
    wr_i  = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d);
    @(negedge clk);
    wr_i  = 1'b0;
    adr_i = a;
    @(posedge clk);
    #1 d = dat_o;
  endtask

  task automatic send_point(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z,
                            output int lat, output logic [95:0] res);
    @(negedge clk);
    pt_ready_i = 1'b1;
    pt_valid_i = 1'b1;
    pt_x_i = x; pt_y_i = y; pt_z_i = z;
    @(posedge clk);
    #1 pt_valid_i = 1'b0;
    lat = 1;
    while (!pt_valid_o && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
    res = {pt_x_o, pt_y_o, pt_z_o};
  endtask

  function automatic logic [95:0] pdat(input int i);
    logic [31:0] x;
    x = 32'h0101_0101 * (i + 1);
    return {x, ~x, x ^ 32'hA5A5_A5A5};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [95:0] res;
    int lat;

    //           cmd   aa            at            x             y             z             ex            ey            ez            stat
    vecs[0] = '{4'h1, 32'h0001_0000, 32'h0002_0000, 32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0003_0000, 32'h0004_0000, 32'h0005_0000, 16'd0};
    vecs[1] = '{4'h1, 32'h0000_8000, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0003, 32'h0000_0001, 32'h0000_0000, 32'h0000_0002, 16'd0};
    vecs[2] = '{4'h3, 32'h0002_0000, 32'h0000_0000, 32'h4000_0000, 32'hC000_0000, 32'hBFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0000, 16'd2};
    vecs[3] = '{4'h1, 32'h0002_0000, 32'h0000_0000, 32'h4000_0000, 32'hC000_0000, 32'hBFFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFE, 16'd2};
    vecs[4] = '{4'h0, 32'h0002_0000, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF, 32'h4000_0000, 32'h1234_5678, 32'hFFFF_FFFF, 32'h4000_0000, 16'd2};
    vecs[5] = '{4'h2, 32'h0002_0000, 32'h0000_0000, 32'h4000_0000, 32'h8000_0000, 32'h7FFF_FFFF, 32'h4000_0000, 32'h8000_0000, 32'h7FFF_FFFF, 16'd2};
    vecs[6] = '{4'h3, 32'h0001_0000, 32'hFFFF_0000, 32'h0000_0000, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_0000, 32'h8000_0000, 32'h7FFE_FFFF, 16'd3};

    rst_n = 1'b0; wr_i = 1'b0; adr_i = 8'h00; dat_i = '0;
    pt_valid_i = 1'b0; pt_ready_i = 1'b1;
    pt_x_i = '0; pt_y_i = '0; pt_z_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset_outputs", {pt_valid_o, pt_x_o, pt_y_o, pt_z_o}, '0);
    chk("reset_dat_o", dat_o, 32'h0);
    chk("reset_ready", pt_ready_o, 1'b1);

    rd(8'h00, d); chk("reset_aa", d, 32'h0001_0000);
    rd(8'h01, d); chk("reset_ab", d, 32'h0);
    rd(8'h3A, d); chk("reset_set3_cc", d, 32'h0001_0000);
    rd(8'h40, d); chk("reset_cmd", d, 32'h0);

    wr(8'h0C, 32'hDEAD_BEEF);
    rd(8'h0C, d); chk("invalid_coef_rd", d, 32'h0);
    rd(8'h42, d); chk("unmapped_rd", d, 32'h0);

    for (int i = 0; i < 7; i++) begin
      wr(8'h40, {28'h0, vecs[i].cmd});
      wr(8'h00, vecs[i].aa); wr(8'h05, vecs[i].aa); wr(8'h0A, vecs[i].aa);
      wr(8'h03, vecs[i].at); wr(8'h07, vecs[i].at); wr(8'h0B, vecs[i].at);
      send_point(vecs[i].x, vecs[i].y, vecs[i].z, lat, res);
      chk($sformatf("vec%0d_latency", i), lat, 3);
      chk($sformatf("vec%0d_x", i), res[95:64], vecs[i].ex);
      chk($sformatf("vec%0d_y", i), res[63:32], vecs[i].ey);
      chk($sformatf("vec%0d_z", i), res[31:0],  vecs[i].ez);
      rd(8'h41, d);
      chk($sformatf("vec%0d_stat", i), d, {16'h0, vecs[i].est});
    end

    rd(8'h40, d); chk("cmd_readback", d, 32'h3);
    wr(8'h41, 32'h0);
    rd(8'h41, d); chk("stat_clear", d, 32'h0);

    // Backpressure: identity transform, pseudo-random downstream ready.
    wr(8'h40, 32'h1);
    wr(8'h00, 32'h0001_0000); wr(8'h05, 32'h0001_0000); wr(8'h0A, 32'h0001_0000);
    wr(8'h03, 32'h0); wr(8'h07, 32'h0); wr(8'h0B, 32'h0);
    begin
      logic [15:0] pat;
      logic        prev_stall;
      logic [95:0] prev_out;
      int sent, rcv, cyc, extra;
      pat = 16'b1011_0010_1110_0101;
      prev_stall = 1'b0; prev_out = '0;
      sent = 0; rcv = 0; cyc = 0;
      while (rcv < 10 && cyc < 200) begin
        @(negedge clk);
        if (prev_stall)
          chk("bp_hold", {pt_valid_o, pt_x_o, pt_y_o, pt_z_o}, {1'b1, prev_out});
        pt_ready_i = pat[cyc % 16];
        pt_valid_i = (sent < 10);
        {pt_x_i, pt_y_i, pt_z_i} = pdat(sent);
        #1;
        if (pt_valid_o && !pt_ready_i)
          chk("bp_ready_low", pt_ready_o, 1'b0);
        if (pt_valid_o && pt_ready_i) begin
          chk($sformatf("bp_order%0d", rcv), {pt_x_o, pt_y_o, pt_z_o}, pdat(rcv));
          rcv++;
        end
        if (pt_valid_i && pt_ready_o)
          sent++;
        prev_stall = pt_valid_o && !pt_ready_i;
        prev_out   = {pt_x_o, pt_y_o, pt_z_o};
        cyc++;
      end
      pt_valid_i = 1'b0;
      chk("bp_count", rcv, 10);
      pt_ready_i = 1'b1;
      extra = 0;
      repeat (5) begin
        @(negedge clk);
        #1 if (pt_valid_o) extra++;
      end
      chk("bp_no_dup", extra, 0);
    end

    // Set switching: set 1 doubles; CMD write lands with the first point.
    wr(8'h10, 32'h0002_0000); wr(8'h15, 32'h0002_0000); wr(8'h1A, 32'h0002_0000);
    begin
      logic [95:0] outs [2];
      int got, cyc;
      @(negedge clk);
      pt_ready_i = 1'b0;
      pt_valid_i = 1'b1;
      pt_x_i = 32'h0001_0000; pt_y_i = 32'h0002_0000; pt_z_i = 32'h0003_0000;
      wr_i = 1'b1; adr_i = 8'h40; dat_i = 32'h5;
      @(negedge clk);
      wr_i = 1'b0;
      @(negedge clk);
      pt_valid_i = 1'b0;
      @(negedge clk);
      #1;
      chk("sw_held_before", {pt_valid_o, pt_x_o, pt_y_o, pt_z_o},
          {1'b1, 32'h0001_0000, 32'h0002_0000, 32'h0003_0000});
      wr(8'h00, 32'h0005_0000);
      wr(8'h10, 32'h0003_0000);
      #1;
      chk("sw_held_after", {pt_valid_o, pt_x_o, pt_y_o, pt_z_o},
          {1'b1, 32'h0001_0000, 32'h0002_0000, 32'h0003_0000});
      chk("sw_ready_low", pt_ready_o, 1'b0);
      got = 0; cyc = 0;
      outs[0] = '0; outs[1] = '0;
      while (got < 2 && cyc < 20) begin
        @(negedge clk);
        pt_ready_i = 1'b1;
        #1;
        if (pt_valid_o) begin
          outs[got] = {pt_x_o, pt_y_o, pt_z_o};
          got++;
        end
        cyc++;
      end
      chk("sw_count", got, 2);
      chk("sw_first_unscaled", outs[0], {32'h0001_0000, 32'h0002_0000, 32'h0003_0000});
      chk("sw_second_doubled", outs[1], {32'h0002_0000, 32'h0004_0000, 32'h0006_0000});
    end

    // Reset with three points in flight.
    pt_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      pt_valid_i = 1'b1;
      {pt_x_i, pt_y_i, pt_z_i} = pdat(i);
    end
    @(negedge clk);
    pt_valid_i = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_outputs", {pt_valid_o, pt_x_o, pt_y_o, pt_z_o}, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rd(8'h00, d); chk("rst_set0_aa", d, 32'h0001_0000);
    rd(8'h10, d); chk("rst_set1_aa", d, 32'h0001_0000);
    rd(8'h15, d); chk("rst_set1_bb", d, 32'h0001_0000);
    rd(8'h40, d); chk("rst_cmd", d, 32'h0);
    rd(8'h41, d); chk("rst_stat", d, 32'h0);
    send_point(32'h1111_1111, 32'h8765_4321, 32'hFFFF_0000, lat, res);
    chk("rst_first_latency", lat, 3);
    chk("rst_first_bypass", res, {32'h1111_1111, 32'h8765_4321, 32'hFFFF_0000});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/any1_point_xform_pipe.md
# any1_point_xform_pipe

Pipelined, parametrised 3-D point transformer. Applies a 3×4 fixed-point affine matrix (3×3 linear part plus translation) to a stream of points under valid/ready flow control. Holds NMAT selectable matrix sets, optional output saturation with a saturation event counter, and fixed-latency bypass. Sits between the graphics command front end and the rasteriser, programmed through the CPU register port.

## Interface
Parameters:
- WID, 32: coefficient and coordinate width, signed two's complement.
- FRAC, 16: fraction bits in coefficients and coordinates; 1 ≤ FRAC < WID.
- NMAT, 4: number of matrix sets; 1..4.

Ports (one clock; reset is asynchronous and active-low):
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- wr_i  in  1  register write strobe.
- adr_i  in  8  register address.
- dat_i  in  WID  write data.
- dat_o  out  WID  registered read data.
- pt_valid_i  in  1  input point valid.
- pt_ready_o  out  1  input accepted when high with pt_valid_i.
- pt_x_i, pt_y_i, pt_z_i  in  WID each  input coordinates.
- pt_valid_o  out  1  output point valid.
- pt_ready_i  in  1  downstream ready.
- pt_x_o, pt_y_o, pt_z_o  out  WID each  output coordinates.

## Operation
- Address map: adr_i[7:6]=0 selects the coefficient bank. adr_i[5:4] is the set and adr_i[3:0] is the coefficient: 0..11 = aa,ab,ac,at,ba,bb,bc,bt,ca,cb,cc,ct. Set ≥ NMAT or coefficient ≥ 12 is ignored on write and reads 0.
- 0x40 CMD: bit0 enable, bit1 sat, bits3:2 active set. A set value ≥ NMAT is clamped to NMAT-1 on write.
- 0x41 STAT: bits15:0 saturation count. Any write clears it; read-only otherwise.
- Other addresses read 0.
- dat_o is registered every cycle from adr_i, so reads have 1-cycle latency.
- Transform, with all arithmetic signed:
  - x' = aa·x + ab·y + ac·z + (at << FRAC)
  - y' and z' are formed the same way from rows b and c.
  - The sum is 2·WID+2 bits wide.
  - Round half-up: add 1 << (FRAC-1), then arithmetic-shift right by FRAC.
- Result range handling, when the shifted result lies outside [-2^(WID-1), 2^(WID-1)-1]:
  - sat=1: clamp to the nearest limit and add 1 to the saturation count per clamped component. The count sticks at 0xFFFF.
  - sat=0: keep the low WID bits (wrap).
- enable=0: the point passes through unchanged with the same latency. Ordering is preserved across mode changes.
- Coefficients, the active set, enable and sat are all sampled when a point enters stage 1. Register writes therefore never affect points already in flight.
- Same-cycle write to the coefficient or CMD being sampled: the point uses the old value.

## Timing
- 3-stage pipeline:
  - S1 registers the 9 products, 3 shifted translations, the bypass coordinates and the mode bits.
  - S2 registers 3 rounded sums.
  - S3 is the output register, with saturate or wrap applied.
- Latency: 3 cycles from acceptance to pt_valid_o with no stall. Throughput is 1 point/cycle.
- Global stall: adv = ~pt_valid_o | pt_ready_i. Every stage and its valid bit load only when adv is high. pt_ready_o = adv, combinational.
- Stall behaviour: while pt_valid_o is high and pt_ready_i is low, all output data and valids hold stable. No point is lost or duplicated.
- STAT clear and a saturation event in the same cycle: clear wins, and the count becomes 0.
- Reset state:
  - All valid bits 0, pt_valid_o 0, pt_x/y/z_o 0, dat_o 0.
  - CMD = 0 (bypass, no sat, set 0) and STAT = 0.
  - All coefficients 0, except aa, bb, cc of every set = 1 << FRAC (identity).
- Reset mid-stream drops every in-flight point. The first output after reset comes 3 cycles after the first new acceptance.

## Structure
- any1_pkg holds the address constants (XF_CMD=8'h40, XF_STAT=8'h41), the coefficient index constants, and the CMD bit-position constants.
- One sub-module, any1_xform_row: one matrix row covering the S1 multiplies, the S2 sum and round, and the S3 saturate. It is instantiated three times.
- The top level owns the register file, the stall logic and the counter.

## Test plan
- Identity transform, translate (2.0, 2.0, 2.0), CMD=1, FRAC=16. Point (0x10000, 0x20000, 0x30000) → (0x30000, 0x40000, 0x50000) exactly 3 cycles after acceptance.
- Rounding with aa=0x8000 (0.5), CMD=1, ab=ac=0, no translate:
  - x=1 → x'=1.
  - x=0xFFFFFFFF (-1) → x'=0.
- Saturation with aa=0x20000 (2.0), x=0x40000000:
  - CMD=3 → x'=0x7FFFFFFF and STAT=1.
  - CMD=1 → x'=0x80000000 and STAT unchanged.
  - Write STAT → reads 0.
- Backpressure: stream 10 points with pt_ready_i toggling in a pseudo-random pattern. Required: outputs arrive in order with none lost or duplicated, data is stable while stalled, and pt_ready_o is low whenever the output is stalled.
- Set switching:
  - Load set 1 with aa=bb=cc=0x20000.
  - Write CMD set=1 between two back-to-back points.
  - Required: the first point comes out unscaled and the second doubled. A coefficient write during a stall does not change the held output.
- Reset: assert rst_ni with 3 points in flight. Required: pt_valid_o=0 immediately, identity coefficients on readback, and CMD reads 0.
